seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed N-digit 7-segment display driver.
- Takes a packed hex value, per-digit decimal points and a 4-bit brightness level, and scans the digits one at a time.
- Generates active-low segment lines and active-high one-hot digit enables, with anti-ghosting dead time, PWM dimming and tear-free frame-synchronous updates.
- Sits between the application counters/registers and the board display pins.

Parameters:
- DIGITS, 4, number of digits scanned; legal 1..8.
- DIV_W, 12, slot counter width; each digit is scanned for 2^DIV_W clocks; legal >= 5.
- BLANK_CYCLES, 16, dead-time clocks at the start of each slot with all digits off; legal 0..2^(DIV_W-4)-1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- value  in  4*DIGITS  hex nibbles; nibble i (value[4i+3:4i]) is shown on digit i; digit 0 is least significant.
- dots  in  DIGITS  decimal point per digit, 1 = lit.
- load  in  1  one-cycle strobe that captures value and dots.
- enable  in  1  0 = display dark (counters keep running).
- brightness  in  4  PWM level; 0 = 1/16 duty, 15 = full duty.
- SEG  out  8  bits 6:0 = segments g..a, bit 7 = dot; all active-low.
- DIG  out  DIGITS  one-hot digit enable, active-high.
- frame_done  out  1  one-cycle pulse at the end of the last digit's slot.

Behaviour:
- Reset (async assert, sync-safe release): slot counter cnt=0, digit index idx=0, pending and display registers=0, SEG=8'hFF, DIG=0, frame_done=0.
- Slot counter cnt (DIV_W bits) increments every clock.
- When cnt wraps at 2^DIV_W-1 -> 0, idx advances: 0,1,...,DIGITS-1,0 (wraps at DIGITS, not a power of 2).
- frame_done is registered. It is 1 on the cycle after the clock where cnt=max and idx=DIGITS-1.
- Frame boundary = that same clock (the wrap into idx=0).
  - display <= pending at the frame boundary.
  - If load is high on the boundary clock, display takes value/dots directly, and pending also captures them.
- load outside a boundary updates pending only; the displayed image never changes mid-frame.
- Per-slot phases (combinational from cnt; phase = cnt[DIV_W-1:DIV_W-4]):
  - BLANK: cnt < BLANK_CYCLES.
  - ON: cnt >= BLANK_CYCLES and phase <= brightness.
  - OFF: otherwise.
- Outputs are registered, one clock after the cnt/idx state:
  - In ON with enable=1: DIG has only bit idx set; SEG[6:0] = font(display nibble idx); SEG[7] = ~dots_display[idx].
  - In BLANK, OFF, or enable=0: DIG=0, SEG=8'hFF.
- Font (hex, SEG[6:0], active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- brightness is sampled live and may change at any time; its effect is visible within the current slot.
- Duty per slot = (brightness+1)/16 minus the BLANK portion.
- Reset asserted mid-scan: outputs go dark immediately (async) and the scan restarts at digit 0 on release.

Optional Feature:
- Macro SEG_LZ_BLANK_EN.
- When defined: leading-zero suppression.
  - Digit i (i >= 1) is blanked (SEG[6:0]=7'h7F) when its display nibble and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - The dot is still driven per dots; DIG still asserts normally.
  - Evaluated on the display register only, so suppression is frame-synchronous.
- When not defined: every digit shows its nibble, including leading zeros.

Test Plan (DIGITS=4, DIV_W=6, BLANK_CYCLES=2):
- Reset then idle, enable=1, brightness=15 -> digit 0 slot: DIG=4'b0001 and SEG=8'hC0 from the cycle cnt=2 is registered (output cycle 3) through cycle 64; 8'hFF/DIG=0 on cycles 1-2 of each slot; frame_done pulses every 256 clocks.
- Pulse load with value=16'h1234, dots=4'b0100 mid-frame -> image unchanged until the next frame_done; then digit0 SEG=8'h99, digit1 8'hB0, digit2 8'h24 (dot lit), digit3 8'hF9.
- load coinciding exactly with the boundary clock -> new image shown in the very next frame's digit 0 slot, with no one-frame delay.
- brightness=0 -> per slot DIG active only at cnt 2..3 (2 clocks); brightness=7 -> active at cnt 2..31; enable=0 -> DIG=0 and SEG=8'hFF throughout.
- Assert RST_N low mid-slot of digit 2 -> SEG=8'hFF and DIG=0 in the same cycle without waiting for a clock edge; after release the scan restarts at digit 0 with display=0.
- With SEG_LZ_BLANK_EN, value=16'h0050 -> digit3 and digit2 SEG[6:0]=7'h7F, digit1 = 7'h12, digit0 = 7'h40; value=0 -> only digit0 shows 7'h40.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// Display driver port bundle: image/brightness controls in, pin-level scan outputs back.
// master = application side, slave = seg_scan_driver.
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dots;
  logic                load;
  logic                enable;
  logic [3:0]          brightness;
  logic [7:0]          SEG;
  logic [DIGITS-1:0]   DIG;
  logic                frame_done;

  modport master (
    output value, dots, load, enable, brightness,
    input  SEG, DIG, frame_done
  );

  modport slave (
    input  value, dots, load, enable, brightness,
    output SEG, DIG, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner with dead time, PWM dimming and frame-synchronous image updates.
// Optional leading-zero suppression when SEG_LZ_BLANK_EN is defined.
module seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int DIV_W        = 12,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  seg_scan_driver_if.slave  bus
);

  localparam int                 IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0]   CNT_MAX  = '1;
  localparam logic [DIV_W-1:0]   BLANK_C  = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIGITS - 1);

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dots_q, pend_dots_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   disp_dots_q, disp_dots_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                fd_q;

  logic       slot_end;
  logic       frame_end;
  logic [3:0] phase;
  logic       lit;

  assign slot_end  = (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (idx_q == IDX_LAST);
  assign phase     = cnt_q[DIV_W-1 -: 4];
  assign lit       = bus.enable && (cnt_q >= BLANK_C) && (phase <= bus.brightness);

  logic [3:0] nib   [DIGITS];
  logic [6:0] glyph [DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nib[gi] = disp_val_q[4*gi +: 4];
    end
  endgenerate

`ifdef SEG_LZ_BLANK_EN
  // zero_hi[i]: nibble i and every nibble above it are zero in the displayed image
  logic [DIGITS:0] zero_hi;
  assign zero_hi[DIGITS] = 1'b1;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign zero_hi[gi] = (nib[gi] == 4'h0) && zero_hi[gi+1];
      if (gi == 0) begin : g_first
        assign glyph[gi] = font(nib[gi]);
      end else begin : g_upper
        assign glyph[gi] = zero_hi[gi] ? 7'h7F : font(nib[gi]);
      end
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_glyph
      assign glyph[gi] = font(nib[gi]);
    end
  endgenerate
`endif

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A load on the boundary clock bypasses pending so the new image is not a frame late
  always_comb begin
    pend_val_d  = pend_val_q;
    pend_dots_d = pend_dots_q;
    if (bus.load) begin
      pend_val_d  = bus.value;
      pend_dots_d = bus.dots;
    end
    disp_val_d  = disp_val_q;
    disp_dots_d = disp_dots_q;
    if (frame_end) begin
      disp_val_d  = pend_val_d;
      disp_dots_d = pend_dots_d;
    end
  end

  always_comb begin
    seg_d = 8'hFF;
    dig_d = '0;
    if (lit) begin
      seg_d        = {~disp_dots_q[idx_q], glyph[idx_q]};
      dig_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_val_q  <= '0;
      pend_dots_q <= '0;
      disp_val_q  <= '0;
      disp_dots_q <= '0;
      seg_q       <= 8'hFF;
      dig_q       <= '0;
      fd_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_val_q  <= pend_val_d;
      pend_dots_q <= pend_dots_d;
      disp_val_q  <= disp_val_d;
      disp_dots_q <= disp_dots_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      fd_q        <= frame_end;
    end
  end

  assign bus.SEG        = seg_q;
  assign bus.DIG        = dig_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, DIV_W=6, BLANK_CYCLES=2): table of images scanned frame by frame.
// Honours SEG_LZ_BLANK_EN when the design is built with it.
module tb_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV_W  = 6;
  localparam int BLANK  = 2;
  localparam int SLOT   = 64;
  localparam int FRAME  = 256;
  localparam int NVEC   = 7;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_driver #(
    .DIGITS       (DIGITS),
    .DIV_W        (DIV_W),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dots;
    logic [3:0]      br;
    logic            en;
    int              load_edge;
    logic [3:0][7:0] exp_seg;
  } vec_t;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       fd;
    int         j;
  } exp_t;

  vec_t            vecs [NVEC];
  exp_t            sb_q [$];
  int              checks = 0;
  int              errors = 0;
  logic [3:0][7:0] cur_seg;
  logic [3:0]      br_cur;
  logic            en_cur;

`ifdef SEG_LZ_BLANK_EN
  function automatic logic [3:0][7:0] lz_adj(input logic [3:0][7:0] s, input logic [15:0] v);
    logic [3:0][7:0] r;
    r = s;
    for (int i = 1; i < 4; i++)
      if ((v >> (4*i)) == 16'h0) r[i][6:0] = 7'h7F;
    return r;
  endfunction
`endif

  function automatic logic [3:0][7:0] image_of(input logic [3:0][7:0] s, input logic [15:0] v);
`ifdef SEG_LZ_BLANK_EN
    return lz_adj(s, v);
`else
    if (v === 16'hxxxx) return '1;
    return s;
`endif
  endfunction

  task automatic set_vec(input int k, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                         input logic e, input int le, input logic [3:0][7:0] s);
    vecs[k].value     = v;
    vecs[k].dots      = d;
    vecs[k].br        = b;
    vecs[k].en        = e;
    vecs[k].load_edge = le;
    vecs[k].exp_seg   = s;
  endtask

  // One frame of expectations: output cycle j reflects cnt=(j-1)%64 of digit (j-1)/64
  task automatic push_window();
    exp_t e;
    int c, d;
    bit act;
    for (int j = 1; j <= FRAME; j++) begin
      c   = (j - 1) % SLOT;
      d   = (j - 1) / SLOT;
      act = en_cur && (c >= BLANK) && ((c >> (DIV_W - 4)) <= int'(br_cur));
      e.seg = act ? cur_seg[d] : 8'hFF;
      e.dig = act ? 4'(1 << d) : 4'h0;
      e.fd  = (j == FRAME);
      e.j   = j;
      sb_q.push_back(e);
    end
  endtask

  task automatic run_window(input int load_edge, input logic [15:0] lv, input logic [3:0] ld);
    exp_t e;
    int errs0;
    errs0 = errors;
    push_window();
    if (load_edge == 1) begin
      bus.value = lv;
      bus.dots  = ld;
      bus.load  = 1'b1;
    end
    for (int j = 1; j <= FRAME; j++) begin
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (bus.SEG !== e.seg || bus.DIG !== e.dig || bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL scan j=%0d: got SEG=%h DIG=%b fd=%b, expected SEG=%h DIG=%b fd=%b",
                 e.j, bus.SEG, bus.DIG, bus.frame_done, e.seg, e.dig, e.fd);
      end
      if (j == load_edge) begin
        bus.load  = 1'b0;
        bus.value = 16'($urandom);
        bus.dots  = 4'($urandom);
      end
      if (j + 1 == load_edge) begin
        bus.value = lv;
        bus.dots  = ld;
        bus.load  = 1'b1;
      end
    end
    $display("frame: br=%0d en=%0b load_edge=%0d image=%h errors_in_frame=%0d",
             br_cur, en_cur, load_edge, cur_seg, errors - errs0);
  endtask

  task automatic check_dark(input string name);
    checks++;
    if (bus.SEG !== 8'hFF || bus.DIG !== 4'h0 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got SEG=%h DIG=%b fd=%b, expected SEG=ff DIG=0000 fd=0",
               name, bus.SEG, bus.DIG, bus.frame_done);
    end
    $display("%s: SEG=%h DIG=%b fd=%b", name, bus.SEG, bus.DIG, bus.frame_done);
  endtask

  initial begin
    set_vec(0, 16'h1234, 4'b0100, 4'd15, 1'b1, 100, {8'hF9, 8'h24, 8'hB0, 8'h99});
    set_vec(1, 16'hABCD, 4'b1001, 4'd15, 1'b1, 256, {8'h08, 8'h83, 8'hC6, 8'h21});
    set_vec(2, 16'h5678, 4'b0000, 4'd0,  1'b1, 1,   {8'h92, 8'h82, 8'hF8, 8'h80});
    set_vec(3, 16'h9EF0, 4'b0010, 4'd7,  1'b1, 256, {8'h90, 8'h86, 8'h0E, 8'hC0});
    set_vec(4, 16'h1111, 4'b1111, 4'd15, 1'b0, 30,  {8'h79, 8'h79, 8'h79, 8'h79});
    set_vec(5, 16'h0050, 4'b0000, 4'd15, 1'b1, 200, {8'hC0, 8'hC0, 8'h92, 8'hC0});
    set_vec(6, 16'h0000, 4'b0001, 4'd3,  1'b1, 256, {8'hC0, 8'hC0, 8'hC0, 8'h40});

    bus.value      = 16'hDEAD;
    bus.dots       = 4'hF;
    bus.load       = 1'b0;
    bus.enable     = 1'b1;
    bus.brightness = 4'd15;
    br_cur         = 4'd15;
    en_cur         = 1'b1;

    #12;
    check_dark("reset_hold");
    #11 RST_N = 1'b1;

    cur_seg = image_of({4{8'hC0}}, 16'h0000);
    run_window(0, 16'h0, 4'h0);

    for (int k = 0; k < NVEC; k++) begin
      br_cur         = vecs[k].br;
      en_cur         = vecs[k].en;
      bus.brightness = vecs[k].br;
      bus.enable     = vecs[k].en;
      run_window(vecs[k].load_edge, vecs[k].value, vecs[k].dots);
      cur_seg = image_of(vecs[k].exp_seg, vecs[k].value);
      run_window(0, 16'h0, 4'h0);
    end

    // Reset in the middle of digit 2's slot, with a nonzero image pending
    br_cur         = 4'd15;
    bus.brightness = 4'd15;
    for (int j = 1; j <= 140; j++) begin
      @(posedge CLK);
      #1;
      if (j == 49) begin
        bus.value = 16'h8888;
        bus.dots  = 4'hF;
        bus.load  = 1'b1;
      end
      if (j == 50) bus.load = 1'b0;
    end
    checks++;
    if (bus.DIG !== 4'b0100 || bus.SEG !== cur_seg[2]) begin
      errors++;
      $display("FAIL digit2_before_reset: got SEG=%h DIG=%b, expected SEG=%h DIG=0100",
               bus.SEG, bus.DIG, cur_seg[2]);
    end
    #2 RST_N = 1'b0;
    #1;
    check_dark("async_reset_immediate");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_dark("reset_held_clocking");
    #4 RST_N = 1'b1;

    cur_seg = image_of({4{8'hC0}}, 16'h0000);
    run_window(0, 16'h0, 4'h0);
    run_window(0, 16'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
